muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit; parametrised successor to the ALU control decode.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_decode.sv | 27 ++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and signedness helpers for the RV32M mul/div unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_MULHSU) || (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_decode.sv
// Combinational fun3 decode: op class, operand signedness and result field select.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [2:0] fun3,
  output logic       is_div_c,
  output logic       sign_a_c,
  output logic       sign_b_c,
  output logic       sel_hi_c,
  output logic       sel_rem_c
);

  // classify the latched op
  always_comb begin
    is_div_c  = 1'b0;
    sign_a_c  = 1'b0;
    sign_b_c  = 1'b0;
    sel_hi_c  = 1'b0;
    sel_rem_c = 1'b0;
    is_div_c  = (fun3 == OP_DIV) || (fun3 == OP_DIVU) || (fun3 == OP_REM) || (fun3 == OP_REMU);
    sign_a_c  = is_signed_a(fun3);
    sign_b_c  = is_signed_b(fun3);
    sel_hi_c  = (fun3 == OP_MULH) || (fun3 == OP_MULHSU) || (fun3 == OP_MULHU);
    sel_rem_c = (fun3 == OP_REM) || (fun3 == OP_REMU);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            fun7,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state, state_next;
  logic            busy_d, done_d, accept_c;

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, opd_q, spec_val_q;
  logic [PW-1:0]   prod_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, spec_q;

  logic            is_div_c, sign_a_c, sign_b_c, sel_hi_c, sel_rem_c;
  logic            a_neg_c, b_neg_c, neg_res_c, div0_c, ovf_c, special_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c, spec_val_c;
  logic [XLEN:0]   sum_c, trial_c;
  logic [PW-1:0]   mul_next_c, div_next_c, mul_fix_c;
  logic [XLEN-1:0] div_sel_c, div_fix_c, fin_c;

  muldiv_decode u_decode (
    .fun3      (op_q),
    .is_div_c  (is_div_c),
    .sign_a_c  (sign_a_c),
    .sign_b_c  (sign_b_c),
    .sel_hi_c  (sel_hi_c),
    .sel_rem_c (sel_rem_c)
  );

  // FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && fun7) state_next = PREP;
      PREP: state_next = special_c ? FIN : CALC;
      CALC: if (cnt_q == CNT_LAST) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs ahead of their output registers
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    accept_c = 1'b0;
    busy_d   = (state_next != IDLE);
    done_d   = (state == FIN);
    accept_c = (state == IDLE) && start && fun7;
  end

  // operand magnitudes, result sign and special-case detection used in PREP
  always_comb begin
    a_neg_c    = sign_a_c & a_q[XLEN-1];
    b_neg_c    = sign_b_c & b_q[XLEN-1];
    abs_a_c    = a_neg_c ? -a_q : a_q;
    abs_b_c    = b_neg_c ? -b_q : b_q;
    neg_res_c  = sel_rem_c ? a_neg_c : (a_neg_c ^ b_neg_c);
    div0_c     = is_div_c && (b_q == '0);
    ovf_c      = is_div_c && sign_a_c && (a_q == XMIN) && (b_q == '1);
    special_c  = div0_c || ovf_c;
    spec_val_c = '0;
    if (div0_c)     spec_val_c = sel_rem_c ? a_q : '1;
    else if (ovf_c) spec_val_c = sel_rem_c ? '0 : XMIN;
  end

  // one shift-add or restoring shift-subtract step
  always_comb begin
    sum_c      = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, opd_q & {XLEN{prod_q[0]}}};
    mul_next_c = {sum_c, prod_q[XLEN-1:1]};
    trial_c    = {prod_q[PW-1:XLEN], prod_q[XLEN-1]} - {1'b0, opd_q};
    if (!trial_c[XLEN]) div_next_c = {trial_c[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    else                div_next_c = {prod_q[PW-2:0], 1'b0};
  end

  // sign fix-up and field select for the final result
  always_comb begin
    mul_fix_c = neg_q ? -prod_q : prod_q;
    div_sel_c = sel_rem_c ? prod_q[PW-1:XLEN] : prod_q[XLEN-1:0];
    div_fix_c = neg_q ? -div_sel_c : div_sel_c;
    if (spec_q)        fin_c = spec_val_q;
    else if (is_div_c) fin_c = div_fix_c;
    else if (sel_hi_c) fin_c = mul_fix_c[PW-1:XLEN];
    else               fin_c = mul_fix_c[XLEN-1:0];
  end

  // datapath registers: latched operands, accumulator, counter, result
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      opd_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_q <= fun3;
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        PREP: begin
          neg_q      <= neg_res_c;
          spec_q     <= special_c;
          spec_val_q <= spec_val_c;
          opd_q      <= is_div_c ? abs_b_c : abs_a_c;
          prod_q     <= {{XLEN{1'b0}}, (is_div_c ? abs_a_c : abs_b_c)};
          cnt_q      <= '0;
        end
        CALC: begin
          prod_q <= is_div_c ? div_next_c : mul_next_c;
          cnt_q  <= cnt_q + CW'(1);
        end
        FIN: begin
          result <= fin_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: XLEN=32 and XLEN=8 instances against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        fun7 = 1'b0;
  logic [2:0]  fun3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        sel = 1'b0;
  int          w = 32;

  logic        start32, start8, busy32, busy8, done32, done8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic        busy_o, done_o;
  logic [31:0] res_o;

  int total = 0;
  int bad = 0;

  assign start32 = start & ~sel;
  assign start8  = start & sel;
  assign busy_o  = sel ? busy8 : busy32;
  assign done_o  = sel ? done8 : done32;
  assign res_o   = sel ? {24'd0, res8} : res32;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .fun7(fun7), .fun3(fun3),
    .op_a(op_a), .op_b(op_b), .busy(busy32), .done(done32), .result(res32)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .fun7(fun7), .fun3(fun3),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]), .busy(busy8), .done(done8), .result(res8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_w(input int wd);
    return 32'((64'd1 << wd) - 64'd1);
  endfunction

  // architectural RV32M semantics evaluated with wide integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b, input int wd);
    longint m, half, ua, ub, sa, sb, r;
    logic [63:0] p;
    m    = (longint'(1) << wd) - 1;
    half = longint'(1) << (wd - 1);
    ua   = longint'({32'd0, a}) & m;
    ub   = longint'({32'd0, b}) & m;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    p    = 64'd0;
    r    = 0;
    case (f3)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      3'd3:       p = 64'(ua * ub);
      3'd4:       r = (ub == 0) ? m : ((sa == -half && sb == -1) ? sa : sa / sb);
      3'd5:       r = (ub == 0) ? m : ua / ub;
      3'd6:       r = (ub == 0) ? ua : ((sa == -half && sb == -1) ? 0 : sa % sb);
      default:    r = (ub == 0) ? ua : ua % ub;
    endcase
    if (f3 == 3'd0) r = longint'(p);
    else if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) r = longint'(p >> wd);
    return 32'(r & m);
  endfunction

  // divide-by-zero and signed overflow finish two cycles after accept, everything else XLEN+2
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, input int wd);
    logic [31:0] m, mn;
    m  = mask_w(wd);
    mn = 32'(64'd1 << (wd - 1));
    if (f3[2] && (b & m) == 32'd0) return 2;
    if ((f3 == 3'd4 || f3 == 3'd6) && (a & m) == mn && (b & m) == m) return 2;
    return wd + 2;
  endfunction

  // map a 32-bit directed operand onto the current width (most-negative stays most-negative)
  function automatic logic [31:0] fit(input logic [31:0] v, input int wd);
    if (v == 32'h8000_0000) return 32'(64'd1 << (wd - 1));
    return v & mask_w(wd);
  endfunction

  // issue one op, scramble operands after accept, wait for done (lat=-1 on timeout)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    fun7 = 1'b1; fun3 = f3; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom; fun3 = 3'($urandom);
    lat = -1; res = 32'd0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done_o) begin
        lat = k; res = res_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state w=%0d: busy=%b done=%b result=%h, want 0/0/0", w, busy_o, done_o, res_o);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f3;
    logic [31:0] a, b, e, res;
    int lat;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:  begin f3 = 3'd0; a = 32'd7;          b = 32'hFFFF_FFFD; e = 32'hFFFF_FFEB; end
        1:  begin f3 = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; e = 32'hFFFF_FFFE; end
        2:  begin f3 = 3'd2; a = 32'hFFFF_FFFF; b = 32'd2;          e = 32'hFFFF_FFFF; end
        3:  begin f3 = 3'd1; a = 32'h8000_0000; b = 32'h8000_0000; e = 32'h4000_0000; end
        4:  begin f3 = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2;          e = 32'hFFFF_FFFD; end
        5:  begin f3 = 3'd6; a = 32'hFFFF_FFF9; b = 32'd2;          e = 32'hFFFF_FFFF; end
        6:  begin f3 = 3'd5; a = 32'd100;        b = 32'd7;          e = 32'd14;        end
        7:  begin f3 = 3'd7; a = 32'd100;        b = 32'd7;          e = 32'd2;         end
        8:  begin f3 = 3'd5; a = 32'd5;          b = 32'd0;          e = 32'hFFFF_FFFF; end
        9:  begin f3 = 3'd6; a = 32'd5;          b = 32'd0;          e = 32'd5;         end
        10: begin f3 = 3'd4; a = 32'h8000_0000; b = 32'hFFFF_FFFF; e = 32'h8000_0000; end
        default: begin f3 = 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; e = 32'd0; end
      endcase
      a = fit(a, w); b = fit(b, w);
      if (w != 32) e = ref_result(f3, a, b, w);
      run_op(f3, a, b, res, lat);
      total++;
      if (res !== e) begin
        bad++;
        $display("FAIL directed_%0d w=%0d result: got %h want %h", i, w, res, e);
      end
      total++;
      if (lat != ref_latency(f3, a, b, w)) begin
        bad++;
        $display("FAIL directed_%0d w=%0d latency: got %0d want %0d", i, w, lat, ref_latency(f3, a, b, w));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, m, res, e;
    int lat, el;
    m = mask_w(w);
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom & m;
      b  = $urandom & m;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = fit(32'h8000_0000, w); b = m; end
        2: b = 32'd1;
        3: a = 32'd0;
        default: ;
      endcase
      e  = ref_result(f3, a, b, w);
      el = ref_latency(f3, a, b, w);
      run_op(f3, a, b, res, lat);
      total++;
      if (res !== e || lat != el) begin
        bad++;
        $display("FAIL random_%0d w=%0d op=%0d a=%h b=%h: got %h/%0d want %h/%0d",
                 i, w, f3, a, b, res, lat, e, el);
      end
    end
  endtask

  task automatic test_ignore();
    logic [31:0] a, b, e, res;
    int lat;
    fun7 = 1'b0; fun3 = 3'd0; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL ignore_fun7 w=%0d busy: got %b want 0", w, busy_o);
    end
    tick();
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL ignore_fun7_done w=%0d: busy=%b done=%b want 0/0", w, busy_o, done_o);
    end
    a = 32'd7; b = fit(32'hFFFF_FFFD, w);
    e = ref_result(3'd0, a, b, w);
    fun7 = 1'b1; fun3 = 3'd0; op_a = a; op_b = b; start = 1'b1;
    tick();
    fun3 = 3'd5; op_a = 32'd50; op_b = 32'd3;
    lat = -1; res = 32'd0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == w) start = 1'b0;
      if (done_o) begin
        lat = k; res = res_o;
        break;
      end
    end
    start = 1'b0;
    total++;
    if (res !== e || lat != w + 2) begin
      bad++;
      $display("FAIL ignore_busy w=%0d: got %h/%0d want %h/%0d", w, res, lat, e, w + 2);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL ignore_after w=%0d: busy=%b done=%b want 0/0", w, busy_o, done_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2, r1, r2;
    int l1, l2;
    a1 = $urandom & mask_w(w); b1 = $urandom & mask_w(w);
    a2 = 32'd100; b2 = 32'd7;
    e1 = ref_result(3'd0, a1, b1, w);
    e2 = ref_result(3'd5, a2, b2, w);
    fun7 = 1'b1; fun3 = 3'd0; op_a = a1; op_b = b1; start = 1'b1;
    tick();
    start = 1'b0;
    l1 = -1; r1 = 32'd0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done_o) begin
        l1 = k; r1 = res_o;
        break;
      end
    end
    // request the second op in the done cycle
    fun3 = 3'd5; op_a = a2; op_b = b2; start = 1'b1;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    l2 = -1; r2 = 32'd0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done_o) begin
        l2 = k; r2 = res_o;
        break;
      end
    end
    total++;
    if (r1 !== e1 || l1 != w + 2) begin
      bad++;
      $display("FAIL b2b_first w=%0d: got %h/%0d want %h/%0d", w, r1, l1, e1, w + 2);
    end
    total++;
    if (r2 !== e2 || l2 != w + 2) begin
      bad++;
      $display("FAIL b2b_second w=%0d: got %h/%0d want %h/%0d", w, r2, l2, e2, w + 2);
    end
  endtask

  task automatic test_reset_abort();
    int into, pulses;
    into = (w == 32) ? 10 : 5;
    fun7 = 1'b1; fun3 = 3'd4; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < into; k++) tick();
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_before w=%0d: got %b want 1", w, busy_o);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== 32'd0) begin
      bad++;
      $display("FAIL abort_state w=%0d: busy=%b done=%b result=%h want 0/0/0", w, busy_o, done_o, res_o);
    end
    pulses = 0;
    for (int k = 0; k < 2 * w + 10; k++) begin
      tick();
      if (done_o) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_done w=%0d: got %0d pulses want 0", w, pulses);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      w   = (s == 1) ? 8 : 32;
      test_reset();
      test_directed();
      test_random();
      test_ignore();
      test_back_to_back();
      test_reset_abort();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
